// File: rtl/mem_lsu_stage_if.sv
// rtl/mem_lsu_stage_if.sv - request, response and RAM port bundle for mem_lsu_stage
interface mem_lsu_stage_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int RAM_W  = 64
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [XLEN-1:0]   req_wdata_i;

  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [XLEN-1:0]   resp_rdata_o;
  logic              resp_err_o;

  logic              ram_r_ena_o;
  logic [ADDR_W-1:0] ram_r_addr_o;
  logic [RAM_W-1:0]  ram_r_data_i;
  logic              ram_w_ena_o;
  logic [ADDR_W-1:0] ram_w_addr_o;
  logic [RAM_W-1:0]  ram_w_data_o;
  logic [RAM_W-1:0]  ram_w_mask_o;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  resp_ready_i, ram_r_data_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output ram_r_ena_o, ram_r_addr_o, ram_w_ena_o, ram_w_addr_o, ram_w_data_o, ram_w_mask_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output resp_ready_i, ram_r_data_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  ram_r_ena_o, ram_r_addr_o, ram_w_ena_o, ram_w_addr_o, ram_w_data_o, ram_w_mask_o
  );
endinterface

// File: rtl/mem_lsu_stage.sv
// rtl/mem_lsu_stage.sv - MEM-stage load/store unit with byte-lane masking and sign/zero extension
// LSU_MISALIGN_TRAP_EN: misaligned requests return an error instead of being aligned down
module mem_lsu_stage #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int RAM_W  = 64
) (
  input  logic           clk,
  input  logic           rst,
  mem_lsu_stage_if.slave bus
);
  localparam int LANE_W = $clog2(RAM_W / 8);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              ram_r_ena_q, ram_r_ena_d;
  logic [ADDR_W-1:0] ram_r_addr_q, ram_r_addr_d;
  logic              ram_w_ena_q, ram_w_ena_d;
  logic [ADDR_W-1:0] ram_w_addr_q, ram_w_addr_d;
  logic [RAM_W-1:0]  ram_w_data_q, ram_w_data_d;
  logic [RAM_W-1:0]  ram_w_mask_q, ram_w_mask_d;

  logic              req_ready;
  logic              accept;
  logic              misalign;
  logic [2:0]        low_bits;
  logic [ADDR_W-1:0] low_mask;
  logic [ADDR_W-1:0] req_addr;
  logic [LANE_W+2:0] wr_shift;
  logic [RAM_W-1:0]  wr_mask;
  logic [RAM_W-1:0]  wr_data;
  logic [RAM_W-1:0]  rd_shifted;
  logic [XLEN-1:0]   ld_mask;
  logic              ld_sign;
  logic [XLEN-1:0]   ld_ext;
  logic [XLEN-1:0]   ld_data;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Request decode: alignment and lane placement happen before anything is latched.
  always_comb begin
    low_bits = 3'((4'b0001 << bus.req_size_i) - 4'b0001);
    low_mask = ADDR_W'(low_bits);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = |(bus.req_addr_i & low_mask);
    req_addr = bus.req_addr_i;
`else
    misalign = 1'b0;
    req_addr = bus.req_addr_i & ~low_mask;
`endif
    wr_shift = {req_addr[LANE_W-1:0], 3'b000};
    wr_mask  = RAM_W'(size_mask(bus.req_size_i)) << wr_shift;
    wr_data  = (RAM_W'(bus.req_wdata_i) & RAM_W'(size_mask(bus.req_size_i))) << wr_shift;
  end

  always_comb begin
    rd_shifted = bus.ram_r_data_i >> {lane_q, 3'b000};
    ld_mask    = XLEN'(size_mask(size_q));
    case (size_q)
      2'd0:    ld_sign = rd_shifted[7];
      2'd1:    ld_sign = rd_shifted[15];
      2'd2:    ld_sign = rd_shifted[31];
      default: ld_sign = rd_shifted[XLEN-1];
    endcase
    ld_ext  = (uns_q || size_q == 2'd3) ? '0 : {XLEN{ld_sign}};
    ld_data = (rd_shifted[XLEN-1:0] & ld_mask) | (ld_ext & ~ld_mask);
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lane_d       = lane_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    ram_r_ena_d  = 1'b0;
    ram_r_addr_d = ram_r_addr_q;
    ram_w_ena_d  = 1'b0;
    ram_w_addr_d = ram_w_addr_q;
    ram_w_data_d = ram_w_data_q;
    ram_w_mask_d = ram_w_mask_q;

    req_ready = (state_q == IDLE) || (state_q == RESP && bus.resp_ready_i);
    accept    = bus.req_valid_i && req_ready;

    case (state_q)
      ACCESS: begin
        if (we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
        resp_err_d   = 1'b0;
      end
      RESP: begin
        if (bus.resp_ready_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // A new accept overrides the RESP drain so back-to-back requests see no bubble.
    if (accept) begin
      we_d   = bus.req_we_i;
      size_d = bus.req_size_i;
      uns_d  = bus.req_unsigned_i;
      lane_d = req_addr[LANE_W-1:0];
      if (misalign) begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 1'b1;
      end else begin
        state_d      = ACCESS;
        resp_valid_d = 1'b0;
        if (bus.req_we_i) begin
          ram_w_ena_d  = 1'b1;
          ram_w_addr_d = req_addr;
          ram_w_data_d = wr_data;
          ram_w_mask_d = wr_mask;
        end else begin
          ram_r_ena_d  = 1'b1;
          ram_r_addr_d = req_addr;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      lane_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      ram_r_ena_q  <= 1'b0;
      ram_r_addr_q <= '0;
      ram_w_ena_q  <= 1'b0;
      ram_w_addr_q <= '0;
      ram_w_data_q <= '0;
      ram_w_mask_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lane_q       <= lane_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      ram_r_ena_q  <= ram_r_ena_d;
      ram_r_addr_q <= ram_r_addr_d;
      ram_w_ena_q  <= ram_w_ena_d;
      ram_w_addr_q <= ram_w_addr_d;
      ram_w_data_q <= ram_w_data_d;
      ram_w_mask_q <= ram_w_mask_d;
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_rdata_o = resp_rdata_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.ram_r_ena_o  = ram_r_ena_q;
  assign bus.ram_r_addr_o = ram_r_addr_q;
  assign bus.ram_w_ena_o  = ram_w_ena_q;
  assign bus.ram_w_addr_o = ram_w_addr_q;
  assign bus.ram_w_data_o = ram_w_data_q;
  assign bus.ram_w_mask_o = ram_w_mask_q;
endmodule

// File: tb/tb_mem_lsu_stage.sv
// tb/tb_mem_lsu_stage.sv - scoreboard bench for mem_lsu_stage with directed vectors
module tb_mem_lsu_stage;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [63:0] ram_val;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  mem_lsu_stage_if #(.XLEN(64), .ADDR_W(64), .RAM_W(64)) bus ();

  mem_lsu_stage #(.XLEN(64), .ADDR_W(64), .RAM_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model returning whatever the current vector preloads.
  always @(posedge clk) if (bus.ram_r_ena_o) bus.ram_r_data_i <= ram_val;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst && bus.resp_valid_o && bus.resp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got rdata %h err %b with empty scoreboard", bus.resp_rdata_o, bus.resp_err_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", bus.resp_rdata_o, e.rdata);
        check("resp_err", 64'(bus.resp_err_o), 64'(e.err));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge (cycle T+1).
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [63:0] addr, input logic [63:0] wdata, output int waits);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wdata;
    waits = 0;
    @(negedge clk);
    while (!bus.req_ready_o && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.req_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.resp_valid_o) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    ram_val = '0;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.resp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    check("rst_resp_rdata", bus.resp_rdata_o, 64'd0);
    check("rst_resp_err", 64'(bus.resp_err_o), 64'd0);
    check("rst_ram_enas", 64'({bus.ram_r_ena_o, bus.ram_w_ena_o}), 64'd0);
    check("rst_ram_w_data", bus.ram_w_data_o, 64'd0);
    check("rst_ram_w_mask", bus.ram_w_mask_o, 64'd0);
    check("rst_ram_addrs", bus.ram_r_addr_o | bus.ram_w_addr_o, 64'd0);
    @(posedge clk); #1;

    // Word store
    push(64'd0, 1'b0);
    send(1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'h0000_0000_DEAD_BEEF, w);
    @(negedge clk);
    check("sw_w_ena", 64'(bus.ram_w_ena_o), 64'd1);
    check("sw_r_ena", 64'(bus.ram_r_ena_o), 64'd0);
    check("sw_w_addr", bus.ram_w_addr_o, 64'h8000_0004);
    check("sw_w_data", bus.ram_w_data_o, 64'hDEAD_BEEF_0000_0000);
    check("sw_w_mask", bus.ram_w_mask_o, 64'hFFFF_FFFF_0000_0000);
    check("sw_valid_t1", 64'(bus.resp_valid_o), 64'd0);
    @(negedge clk);
    check("sw_valid_t2", 64'(bus.resp_valid_o), 64'd1);
    check("sw_w_ena_off", 64'(bus.ram_w_ena_o), 64'd0);
    @(negedge clk);
    check("sw_valid_t3", 64'(bus.resp_valid_o), 64'd0);
    @(posedge clk); #1;

    // LB with latency checks
    ram_val = 64'h0000_0000_8000_0000;
    push(64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    send(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0, w);
    @(negedge clk);
    check("lb_r_ena", 64'(bus.ram_r_ena_o), 64'd1);
    check("lb_r_addr", bus.ram_r_addr_o, 64'h8000_0003);
    check("lb_w_ena", 64'(bus.ram_w_ena_o), 64'd0);
    @(negedge clk);
    check("lb_valid_t2", 64'(bus.resp_valid_o), 64'd0);
    @(negedge clk);
    check("lb_valid_t3", 64'(bus.resp_valid_o), 64'd1);
    @(posedge clk); #1;

    push(64'h0000_0000_0000_0080, 1'b0);
    send(1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'd0, w);
    wait_done();

    // Half store with garbage above the half in wdata
    push(64'd0, 1'b0);
    send(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'hFFFF_FFFF_FFFF_1234, w);
    @(negedge clk);
    check("sh_w_data", bus.ram_w_data_o, 64'h1234_0000_0000_0000);
    check("sh_w_mask", bus.ram_w_mask_o, 64'hFFFF_0000_0000_0000);
    wait_done();

    ram_val = 64'h0000_0000_F00D_0000;
    push(64'hFFFF_FFFF_FFFF_F00D, 1'b0);
    send(1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'd0, w);
    wait_done();

    ram_val = 64'h89AB_CDEF_0000_0000;
    push(64'hFFFF_FFFF_89AB_CDEF, 1'b0);
    send(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0, w);
    wait_done();
    push(64'h0000_0000_89AB_CDEF, 1'b0);
    send(1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'd0, w);
    wait_done();

    // Misaligned double load
    ram_val = 64'h1122_3344_5566_7788;
`ifdef LSU_MISALIGN_TRAP_EN
    push(64'd0, 1'b1);
    send(1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'd0, w);
    @(negedge clk);
    check("ld_mis_r_ena", 64'(bus.ram_r_ena_o), 64'd0);
    check("ld_mis_valid_t1", 64'(bus.resp_valid_o), 64'd1);
`else
    push(64'h1122_3344_5566_7788, 1'b0);
    send(1'b0, 2'd3, 1'b1, 64'h8000_0004, 64'd0, w);
    @(negedge clk);
    check("ld_mis_r_ena", 64'(bus.ram_r_ena_o), 64'd1);
    check("ld_mis_r_addr", bus.ram_r_addr_o, 64'h8000_0000);
`endif
    wait_done();

    // Response backpressure, then release with a new request waiting
    bus.resp_ready_i = 1'b0;
    ram_val = 64'h0000_0000_8000_0000;
    push(64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    send(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0, w);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.resp_valid_o && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_valid", 64'(bus.resp_valid_o), 64'd1);
      check("bp_rdata", bus.resp_rdata_o, 64'hFFFF_FFFF_FFFF_FF80);
      check("bp_err", 64'(bus.resp_err_o), 64'd0);
      check("bp_req_ready", 64'(bus.req_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b1;
    push(64'd0, 1'b0);
    send(1'b1, 2'd0, 1'b0, 64'h8000_0001, 64'h0000_0000_0000_00AB, w);
    check("bp_accept_waits", 64'(w), 64'd0);
    @(negedge clk);
    check("bp_next_w_ena", 64'(bus.ram_w_ena_o), 64'd1);
    check("bp_next_w_data", bus.ram_w_data_o, 64'h0000_0000_0000_AB00);
    check("bp_next_w_mask", bus.ram_w_mask_o, 64'h0000_0000_0000_FF00);
    check("bp_next_valid", 64'(bus.resp_valid_o), 64'd0);
    wait_done();

    // Asynchronous reset during a store's ACCESS cycle
    send(1'b1, 2'd2, 1'b0, 64'h8000_0010, 64'h0000_0000_0000_0055, w);
    check("ar_pre_w_ena", 64'(bus.ram_w_ena_o), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("ar_w_ena", 64'(bus.ram_w_ena_o), 64'd0);
    check("ar_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    check("ar_w_data", bus.ram_w_data_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ar_req_ready", 64'(bus.req_ready_o), 64'd1);
    check("ar_valid_after", 64'(bus.resp_valid_o), 64'd0);
    @(negedge clk);
    check("ar_no_resp", 64'(bus.resp_valid_o), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end
endmodule
